// File: rtl/store_queue_pkg.sv
// Shared types and default widths for the store queue.
// The entry struct gives the canonical layout at the default widths.
package store_queue_pkg;

  localparam int unsigned NUM_D_REG  = 32;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_TAG_W  = $clog2(NUM_D_REG);

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_ADDR_W-1:0] mem_addr;
    logic [DEF_TAG_W-1:0]  reg_tag;
  } sq_entry_t;

endpackage

// File: rtl/store_queue_fwd.sv
// Store-to-load forwarding match: among valid entries whose address equals
// ld_addr, returns the data of the youngest one.
module store_queue_fwd
  import store_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned IDX_W  = 3
) (
  input  logic [DEPTH-1:0]  valid,
  input  logic [ADDR_W-1:0] addr [DEPTH],
  input  logic [DATA_W-1:0] data [DEPTH],
  input  logic [IDX_W-1:0]  head,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  localparam int unsigned SW = IDX_W + 1;

  logic [SW-1:0]    sum;
  logic [IDX_W-1:0] idx;

  // Walk oldest to youngest from head; a later match overrides an earlier one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    sum      = '0;
    idx      = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      sum = {1'b0, head} + SW'(k);
      if (sum >= SW'(DEPTH)) begin
        sum = sum - SW'(DEPTH);
      end
      idx = sum[IDX_W-1:0];
      if (valid[idx] && (addr[idx] == ld_addr)) begin
        hit      = 1'b1;
        hit_data = data[idx];
      end
    end
  end

endmodule

// File: rtl/store_queue.sv
// In-order store queue with ready/valid on both ends, occupancy, flush and
// youngest-match store-to-load forwarding.
module store_queue
  import store_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned TAG_W  = $clog2(NUM_D_REG),
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              flush,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [TAG_W-1:0]  push_tag,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic [ADDR_W-1:0] pop_addr,
  output logic [TAG_W-1:0]  pop_tag,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hit,
  output logic [DATA_W-1:0] ld_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] mem_addr;
    logic [TAG_W-1:0]  reg_tag;
  } entry_t;

  logic             push_fire;
  logic             pop_fire;
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  entry_t           mem_q [DEPTH];
  entry_t           push_entry;

  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];

  // Explicit wrap so non-power-of-two depths work without a modulo.
  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(DEPTH - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign push_ready = ~full;
  assign pop_valid  = ~empty;
  assign push_fire  = push_valid & push_ready;
  assign pop_fire   = pop_valid & pop_ready;

  assign push_entry = '{data: push_data, mem_addr: push_addr, reg_tag: push_tag};

  assign pop_data = mem_q[head_q].data;
  assign pop_addr = mem_q[head_q].mem_addr;
  assign pop_tag  = mem_q[head_q].reg_tag;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
    end else begin
      if (push_fire) begin
        tail_d          = ptr_inc(tail_q);
        valid_d[tail_q] = 1'b1;
      end
      if (pop_fire) begin
        head_d          = ptr_inc(head_q);
        valid_d[head_q] = 1'b0;
      end
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!n_rst) begin
        mem_q[i] <= '0;
      end else if (push_fire && !flush && (tail_q == IDX_W'(i))) begin
        mem_q[i] <= push_entry;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_addr[i] = mem_q[i].mem_addr;
      ent_data[i] = mem_q[i].data;
    end
  end

  store_queue_fwd #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_fwd (
    .valid    (valid_q),
    .addr     (ent_addr),
    .data     (ent_data),
    .head     (head_q),
    .ld_addr  (ld_addr),
    .hit      (ld_hit),
    .hit_data (ld_data)
  );

endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue at DEPTH=5: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_store_queue;

  localparam int unsigned DEPTH = 5;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 16;
  localparam int unsigned TW    = 5;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          flush;
  logic          push_valid;
  logic          push_ready;
  logic [DW-1:0] push_data;
  logic [AW-1:0] push_addr;
  logic [TW-1:0] push_tag;
  logic          pop_valid;
  logic          pop_ready;
  logic [DW-1:0] pop_data;
  logic [AW-1:0] pop_addr;
  logic [TW-1:0] pop_tag;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  always #5 clk = ~clk;

  store_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (DW),
    .ADDR_W (AW),
    .TAG_W  (TW)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .push_addr  (push_addr),
    .push_tag   (push_tag),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_data   (pop_data),
    .pop_addr   (pop_addr),
    .pop_tag    (pop_tag),
    .ld_addr    (ld_addr),
    .ld_hit     (ld_hit),
    .ld_data    (ld_data),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic [TW-1:0] tag;
  } ent_t;

  ent_t mdl[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   armed       = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of entries, updated on each clock edge.
  always @(posedge clk) begin
    bit do_push;
    do_push = 1'b0;
    if (!n_rst) begin
      mdl.delete();
      armed <= 1'b1;
    end else if (flush) begin
      mdl.delete();
    end else begin
      do_push = push_valid && (mdl.size() < DEPTH);
      if (pop_ready && (mdl.size() > 0)) void'(mdl.pop_front());
      if (do_push) mdl.push_back('{push_data, push_addr, push_tag});
    end
  end

  // Monitor: compare status every cycle; compare head entry whenever the DUT presents one.
  always @(negedge clk) begin
    int            n;
    logic          exp_hit;
    logic [DW-1:0] exp_ld;
    if (armed) begin
      n = mdl.size();
      check("count", 32'(count), 32'(n));
      check("full", 32'(full), 32'(n == DEPTH));
      check("empty", 32'(empty), 32'(n == 0));
      check("push_ready", 32'(push_ready), 32'(n < DEPTH));
      check("pop_valid", 32'(pop_valid), 32'(n > 0));
      if (pop_valid && n > 0) begin
        check("pop_data", 32'(pop_data), 32'(mdl[0].data));
        check("pop_addr", 32'(pop_addr), 32'(mdl[0].addr));
        check("pop_tag", 32'(pop_tag), 32'(mdl[0].tag));
      end
      exp_hit = 1'b0;
      exp_ld  = '0;
      foreach (mdl[i]) begin
        if (mdl[i].addr == ld_addr) begin
          exp_hit = 1'b1;
          exp_ld  = mdl[i].data;
        end
      end
      check("ld_hit", 32'(ld_hit), 32'(exp_hit));
      check("ld_data", 32'(ld_data), 32'(exp_ld));
    end
  end

  task automatic drive(input bit pv, input logic [DW-1:0] d, input logic [AW-1:0] a,
                       input logic [TW-1:0] t, input bit pr, input bit fl);
    push_valid = pv;
    push_data  = d;
    push_addr  = a;
    push_tag   = t;
    pop_ready  = pr;
    flush      = fl;
    @(posedge clk);
    #2;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_push_ready"}, 32'(push_ready), 32'd1);
    check({tag, "_pop_valid"}, 32'(pop_valid), 32'd0);
    check({tag, "_ld_hit"}, 32'(ld_hit), 32'd0);
    check({tag, "_ld_data"}, 32'(ld_data), 32'd0);
    check({tag, "_pop_data"}, 32'(pop_data), 32'd0);
    check({tag, "_pop_addr"}, 32'(pop_addr), 32'd0);
    check({tag, "_pop_tag"}, 32'(pop_tag), 32'd0);
  endtask

  initial begin
    n_rst   = 1'b0;
    ld_addr = '0;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    n_rst = 1'b1;
    reset_checks("rst");

    // Three pushes, then drain in order.
    drive(1, 16'h000A, 16'h0010, 5'd1, 0, 0);
    drive(1, 16'h000B, 16'h0020, 5'd2, 0, 0);
    drive(1, 16'h000C, 16'h0030, 5'd3, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("three_count", 32'(count), 32'd3);
    check("three_head", 32'(pop_data), 32'h000A);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0);
    check("three_empty", 32'(empty), 32'd1);

    // Fill, drop on full, then wrap the tail.
    for (int i = 0; i < 5; i++) drive(1, 16'(16'h0100 + i), 16'(16'h0060 + i), 5'(i), 0, 0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_push_ready", 32'(push_ready), 32'd0);
    drive(1, 16'hDEAD, 16'h0070, 5'd9, 0, 0);
    check("drop_count", 32'(count), 32'd5);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 16'h0200, 16'h0080, 5'd10, 0, 0);
    drive(1, 16'h0201, 16'h0081, 5'd11, 0, 0);
    check("wrap_full", 32'(full), 32'd1);
    check("wrap_head", 32'(pop_data), 32'h0102);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 0);
    check("wrap_empty", 32'(empty), 32'd1);

    // Youngest-match forwarding.
    drive(1, 16'h1111, 16'h0040, 5'd4, 0, 0);
    drive(1, 16'h2222, 16'h0040, 5'd5, 0, 0);
    ld_addr = 16'h0040;
    drive(0, 0, 0, 0, 0, 0);
    check("fwd_hit", 32'(ld_hit), 32'd1);
    check("fwd_data", 32'(ld_data), 32'h2222);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    check("fwd_gone_hit", 32'(ld_hit), 32'd0);
    check("fwd_gone_data", 32'(ld_data), 32'd0);

    // Steady state: push and pop every cycle.
    for (int i = 0; i < 3; i++) drive(1, 16'(16'h0300 + i), 16'h0050, 5'(i), 0, 0);
    for (int i = 0; i < 10; i++) drive(1, 16'(16'h0400 + i), 16'h0050, 5'(i), 1, 0);
    check("steady_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0);

    // Flush beats a push in the same cycle.
    for (int i = 0; i < 4; i++) drive(1, 16'(16'h0500 + i), 16'h0040, 5'(i), 0, 0);
    drive(1, 16'h0599, 16'h0040, 5'd7, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_ld_hit", 32'(ld_hit), 32'd0);

    // Reset mid-stream.
    drive(1, 16'h0600, 16'h0040, 5'd1, 0, 0);
    drive(1, 16'h0601, 16'h0040, 5'd2, 0, 0);
    n_rst = 1'b0;
    drive(1, 16'h0602, 16'h0040, 5'd3, 1, 0);
    n_rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    reset_checks("midrst");

    // Random traffic over a small address set so forwarding hits often.
    for (int i = 0; i < 3000; i++) begin
      n_rst   = ($urandom_range(0, 199) != 0);
      ld_addr = 16'(16'h0010 * $urandom_range(1, 4));
      drive(bit'($urandom_range(0, 2) != 0), 16'($urandom), 16'(16'h0010 * $urandom_range(1, 4)),
            5'($urandom_range(0, 31)), bit'($urandom_range(0, 2) == 0),
            bit'($urandom_range(0, 63) == 0));
    end
    n_rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/store_queue.md
# store_queue

Parametrised in-order store queue for the out-of-order memory path. Holds pending stores (data, memory address, destination register tag) between issue and memory commit, with ready/valid handshakes on both ends, occupancy reporting, flush, and a youngest-match store-to-load forwarding port. Sits between the dispatch/execute stage and the data-memory port, replacing the fixed 16-bit unhandshaken queue.

## Interface
- DEPTH, 8, number of entries; any integer ≥ 2 (power of two not required)
- DATA_W, 16, store data width
- ADDR_W, 16, memory address width
- TAG_W, $clog2(`NUM_D_REG), register tag width
- clk  in  1  clock
- n_rst  in  1  reset; synchronous, active-low
- flush  in  1  discard all entries
- push_valid  in  1  producer offers an entry
- push_ready  out  1  queue can accept; = ~full
- push_data / push_addr / push_tag  in  DATA_W / ADDR_W / TAG_W  incoming entry
- pop_valid  out  1  head entry present; = ~empty
- pop_ready  in  1  consumer takes head
- pop_data / pop_addr / pop_tag  out  DATA_W / ADDR_W / TAG_W  head entry
- ld_addr  in  ADDR_W  load address to check
- ld_hit  out  1  some valid entry has mem_addr == ld_addr
- ld_data  out  DATA_W  data of youngest matching entry; 0 when no hit
- count  out  $clog2(DEPTH+1)  current occupancy
- full, empty  out  1  count == DEPTH, count == 0

## Operation
- Push fires when push_valid & push_ready; entry written at tail, tail advances, entry valid bit set.
- Pop fires when pop_valid & pop_ready; head valid bit cleared, head advances.
- Pointers wrap DEPTH-1 → 0 by explicit compare; no modulo on non-power-of-two.
- Simultaneous push and pop fire: both happen, count unchanged. On full, push_ready is 0 even if pop fires same cycle (no same-cycle bypass).
- Push/pop with fire condition false: no state change; data inputs ignored.
- Forwarding: combinational compare of ld_addr against all valid entries; among hits, youngest (closest behind tail) wins. Entry being pushed in current cycle is not visible; entry being popped in current cycle still visible.
- flush: highest priority after reset; next cycle head = tail = count = 0, all valid bits 0; push/pop in the flush cycle are ignored. Storage contents need not be cleared.
- Reset: head, tail, count, valid bits = 0; storage = 0. Outputs after reset: push_ready 1, pop_valid 0, empty 1, full 0, count 0, ld_hit 0, ld_data 0, pop_* 0.
- No fall-through: an entry pushed into an empty queue appears on pop_* one cycle later.

## Timing
- All state updates on posedge clk.
- push → pop_valid: 1 cycle.
- pop_* driven combinationally from storage at head; stable while pop_valid & ~pop_ready.
- count, full, empty, push_ready, pop_valid are registered-state functions (no combinational path from push_valid/pop_ready).
- ld_hit/ld_data: combinational from ld_addr and state, 0-cycle.
- Reset/flush mid-operation: applies next edge regardless of handshakes in flight.

## Structure
- Shared package holds the entry struct (data, mem_addr, reg_tag) built from default widths, plus `NUM_D_REG` and default DATA_W/ADDR_W constants; module uses local typedef when widths are overridden.
- One sub-module: store_queue_fwd — age-ordered priority match (inputs: valid vector, address array, data array, head index, ld_addr; outputs: hit, data).

## Test plan
- Reset, then push 3 entries (addr 0x10/0x20/0x30, data 0xA/0xB/0xC) → count 3; pops return them in order, empty after third pop.
- DEPTH=5: push 5 → full=1, push_ready=0, push during full is dropped; pop 2, push 2 → tail wraps 4→0→1, data order preserved.
- Push 0x1111@0x40 then 0x2222@0x40, ld_addr=0x40 → ld_hit 1, ld_data 0x2222; pop both → ld_hit 0, ld_data 0.
- Count 3, push and pop fire same cycle for 10 cycles → count stays 3, FIFO order intact.
- Count 4, assert flush with push_valid=1 → next cycle empty=1, count 0, pushed entry absent.
- Count 2, assert n_rst=0 mid-stream → next cycle all outputs at reset values listed above.
